// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter driving a registered shared data mux.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   req_a/b   - request from requester A / B
//   data_a/b  - WIDTH-bit data word from requester A / B
//   grant_a/b - A / B owns the mux this cycle (decoded from state)
//   sel       - mux select, 0 = A path, 1 = B path
//   out       - registered mux output, one cycle after the grant cycle
//   out_valid - out carries a granted word
module mux_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);
    localparam int CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             enter;
    always_comb begin
        state_d = state_q;
        case (state_q)
            // tie goes to whoever did not hold the grant last (last_q=1 means B)
            IDLE:    state_d = (req_a && req_b) ? (last_q ? GNT_A : GNT_B) :
                               req_a ? GNT_A : req_b ? GNT_B : IDLE;
            // burst limit only forces a handover when the other side is waiting
            GNT_A:   state_d = !req_a ? (req_b ? GNT_B : IDLE) :
                               (req_b && cnt_q == CMAX) ? GNT_B : GNT_A;
            GNT_B:   state_d = !req_b ? (req_a ? GNT_A : IDLE) :
                               (req_a && cnt_q == CMAX) ? GNT_A : GNT_B;
            default: state_d = IDLE;
        endcase
        enter   = (state_d != state_q) && (state_d != IDLE);
        cnt_d   = (enter || state_d == IDLE) ? '0 :
                  (cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;
        last_d  = enter ? (state_d == GNT_B) : last_q;
        out_d   = grant_a ? data_a : grant_b ? data_b : '0;
        valid_d = grant_a | grant_b;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end
    assign grant_a   = (state_q == GNT_A);
    assign grant_b   = (state_q == GNT_B);
    assign sel       = grant_b;
    assign out       = out_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: self-checking bench for mux_arbiter against an ownership-level reference model.
module tb_mux_arbiter;
    localparam int WIDTH = 16;
    localparam int MAXB  = 4;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0;
    logic [WIDTH-1:0] data_a = '0, data_b = '0;
    logic             grant_a, grant_b, sel, out_valid;
    logic [WIDTH-1:0] out;
    int errors = 0;
    int checks = 0;
    // reference model: owner 0=none 1=A 2=B, last owner, cycles held so far
    int own, last, held;
    logic [WIDTH-1:0] exp_out;
    logic             exp_v;
    int run_a, run_b;
    mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .grant_a(grant_a), .grant_b(grant_b),
        .sel(sel), .out(out), .out_valid(out_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        own = 0; last = 2; held = 0; exp_out = '0; exp_v = 1'b0; run_a = 0; run_b = 0;
    endtask
    task automatic check_all();
        chk("grant_a", grant_a, own == 1);
        chk("grant_b", grant_b, own == 2);
        chk("sel", sel, own == 2);
        chk("out", out, exp_out);
        chk("out_valid", out_valid, exp_v);
        chk("exclusive", grant_a & grant_b, 0);
    endtask
    task automatic step(input logic ra, input logic rb, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        int nxt;
        req_a = ra; req_b = rb; data_a = da; data_b = db;
        run_a = (grant_a && rb) ? run_a + 1 : 0;
        run_b = (grant_b && ra) ? run_b + 1 : 0;
        @(posedge clk);
        exp_out = (own == 1) ? da : (own == 2) ? db : '0;
        exp_v   = (own != 0);
        if (own == 0)
            nxt = (ra && rb) ? ((last == 1) ? 2 : 1) : ra ? 1 : rb ? 2 : 0;
        else if (own == 1)
            nxt = !ra ? (rb ? 2 : 0) : (rb && held >= MAXB) ? 2 : 1;
        else
            nxt = !rb ? (ra ? 1 : 0) : (ra && held >= MAXB) ? 1 : 2;
        if (nxt != 0 && nxt != own) begin
            held = 1;
            last = nxt;
        end else if (nxt != 0) begin
            held++;
        end
        own = nxt;
        #1;
        check_all();
    endtask
    task automatic do_reset();
        rst_n = 1'b0; req_a = 0; req_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        model_reset();
        #2;
        check_all();
        do_reset();
        check_all();
        // continuous contention: A 1-4, B 5-8, A 9-12
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 16'(i), 16'(16'h100 + i));
            chk("tie_seq_a", grant_a, (i <= 4) || (i >= 9));
            chk("tie_seq_b", grant_b, (i >= 5) && (i <= 8));
        end
        // lone requester keeps the grant, out follows one cycle later
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 16'h1234, 16'h0);
            chk("lone_grant", grant_a, 1);
            if (i > 1) chk("lone_out", out, 16'h1234);
        end
        // handover without an idle bubble
        step(0, 1, 16'h0, 16'hBEEF);
        chk("handover_b", grant_b, 1);
        chk("handover_sel", sel, 1);
        step(0, 1, 16'h0, 16'hBEEF);
        chk("handover_out", out, 16'hBEEF);
        // both drop -> idle, then output clears
        step(0, 0, 16'h0, 16'h0);
        chk("drop_idle", {grant_a, grant_b}, 0);
        step(0, 0, 16'h0, 16'h0);
        chk("drop_out", out, 0);
        chk("drop_valid", out_valid, 0);
        // asynchronous reset mid GNT_B, then tie must go to A
        step(0, 1, 16'h0, 16'h5555);
        step(0, 1, 16'h0, 16'h6666);
        chk("pre_rst_b", grant_b, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant_b", grant_b, 0);
        chk("async_valid", out_valid, 0);
        chk("async_out", out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 16'hAAAA, 16'hBBBB);
        chk("post_rst_tie", grant_a, 1);
        // randomized stress
        for (int i = 0; i < 2000; i++) begin
            logic ra, rb;
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
            step(ra, rb, 16'($urandom), 16'($urandom));
            chk("burst_limit", (run_a <= MAXB) && (run_b <= MAXB), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
